vga_scanout: RTL and testbench

Display back end of the PPU path. Continuously reads the 256×240 palette-index frame that `ppu_fsm` writes into `vga_mem`, scales it 2× into a 640×480@60 VGA raster with a 64-pixel black border left and right, and converts each index to 12-bit RGB. Owns the `vga_done` handshake that tells `ppu_fsm` when frame memory is free for rendering.

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_scanout_if.sv | 18 +
 rtl/nes_palette_lut.sv | 22 ++
 rtl/vga_scanout.sv | 186 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, handshake state type and the NES master palette
// used by the VGA scanout back end.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_X_OFFSET = 64;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // 256 source columns doubled horizontally
  localparam int unsigned PIC_W = 512;

  typedef enum logic {
    SCAN,
    WAIT_PPU
  } scan_state_t;

  localparam logic [11:0] NES_PALETTE [0:63] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-memory read port plus the PPU/scanout frame handshake.
interface vga_scanout_if;
  logic [9:0] vga_read_row;
  logic [9:0] vga_read_col;
  logic [7:0] vga_read_data;
  logic       ppu_vsync;
  logic       vga_done;

  modport master (
    output vga_read_row, vga_read_col, vga_done,
    input  vga_read_data, ppu_vsync
  );

  modport slave (
    input  vga_read_row, vga_read_col, vga_done,
    output vga_read_data, ppu_vsync
  );
endinterface

// File: rtl/nes_palette_lut.sv
// Registered palette lookup (stage S2): 6-bit NES colour index to 12-bit RGB,
// forced to black outside the picture region.
module nes_palette_lut
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        pic,
  input  logic [5:0]  idx,
  output logic [11:0] rgb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= '0;
    end else if (en) begin
      rgb <= pic ? NES_PALETTE[idx] : '0;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA back end: pixel divider, raster counters, 2x-scaled frame-memory
// addressing, aligned sync delay line and the vga_done frame handshake.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned X_OFFSET = DEF_X_OFFSET
) (
  input  logic                clk,
  input  logic                rst,
  vga_scanout_if.master       mem_bus,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic [7:0]          overrun_count
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] PIC_X0   = 10'(X_OFFSET);
  localparam logic [9:0] PIC_X1   = 10'(X_OFFSET + PIC_W);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [9:0]       h;
  logic [9:0]       v;

  logic        in_pic;
  logic        hs_n;
  logic        vs_n;
  logic [9:0]  read_row;
  logic [9:0]  read_col;
  logic        pic_s1;
  logic        hs_s1;
  logic        vs_s1;
  logic        hs_s2;
  logic        vs_s2;
  logic [11:0] rgb;

  scan_state_t state;
  scan_state_t state_nx;
  logic        vsync_prev;
  logic        vsync_rise;
  logic        frame_end;
  logic        frame_start;
  logic [7:0]  overrun;
  logic [7:0]  overrun_nx;
  logic        unused_data_hi;

  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // S0: raster position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_comb begin
    in_pic = (h >= PIC_X0) && (h < PIC_X1) && (v < V_ACT);
    hs_n   = !((h >= HS_START) && (h < HS_END));
    vs_n   = !((v >= VS_START) && (v < VS_END));
  end

  // S1: memory address; sync and picture flag travel alongside the pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_row <= '0;
      read_col <= '0;
      pic_s1   <= 1'b0;
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      hs_s2    <= 1'b1;
      vs_s2    <= 1'b1;
    end else if (pix_en) begin
      if (in_pic) begin
        read_row <= v >> 1;
        read_col <= (h - PIC_X0) >> 1;
      end
      pic_s1 <= in_pic;
      hs_s1  <= hs_n;
      vs_s1  <= vs_n;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
    end
  end

  // S2: palette lookup on the data returned for the S1 address
  nes_palette_lut u_palette (
    .clk   (clk),
    .rst_n (rst),
    .en    (pix_en),
    .pic   (pic_s1),
    .idx   (mem_bus.vga_read_data[5:0]),
    .rgb   (rgb)
  );

  assign unused_data_hi = ^mem_bus.vga_read_data[7:6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCAN;
      vsync_prev <= 1'b0;
      overrun    <= '0;
    end else begin
      state      <= state_nx;
      vsync_prev <= mem_bus.ppu_vsync;
      overrun    <= overrun_nx;
    end
  end

  // A PPU frame-complete edge coinciding with frame start wins over overrun
  always_comb begin
    state_nx    = state;
    overrun_nx  = overrun;
    vsync_rise  = mem_bus.ppu_vsync && !vsync_prev;
    frame_end   = pix_en && (h == H_LAST) && (v == V_ACT_LAST);
    frame_start = pix_en && (h == '0) && (v == '0);
    case (state)
      SCAN: begin
        if (frame_end) begin
          state_nx = WAIT_PPU;
        end
      end
      WAIT_PPU: begin
        if (vsync_rise) begin
          state_nx = SCAN;
        end else if (frame_start && (overrun != 8'hFF)) begin
          overrun_nx = overrun + 1'b1;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  assign mem_bus.vga_read_row = read_row;
  assign mem_bus.vga_read_col = read_col;
  assign mem_bus.vga_done     = (state == WAIT_PPU);
  assign vga_r                = rgb[11:8];
  assign vga_g                = rgb[7:4];
  assign vga_b                = rgb[3:0];
  assign vga_hs               = hs_s2;
  assign vga_vs               = vs_s2;
  assign overrun_count        = overrun;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shortened raster (656x10 ticks per
// frame, CLK_DIV=2); frame memory returns {row[1:0], col[5:0]}.
module tb_vga_scanout;

  localparam int unsigned HT = 656;
  localparam int unsigned VT = 10;
  localparam int unsigned FT = HT * VT;

  typedef enum int { S_RGB, S_ROW, S_COL, S_DONE, S_OVR, S_HS, S_VS } sel_t;

  typedef struct {
    int unsigned due;
    sel_t        sel;
    int unsigned exp;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs;
  logic [7:0] overrun_count;

  int unsigned cyc;
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  vec_t        sb_q[$];

  vga_scanout_if bus ();

  vga_scanout #(
    .CLK_DIV  (2),
    .H_ACTIVE (640),
    .H_FP     (4),
    .H_SYNC   (8),
    .H_BP     (4),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .X_OFFSET (64)
  ) dut (
    .clk           (clk),
    .rst           (rst_n),
    .mem_bus       (bus),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    bus.vga_read_data <= {bus.vga_read_row[1:0], bus.vga_read_col[5:0]};
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned actual(input sel_t sel);
    case (sel)
      S_RGB:   return {20'd0, vga_r, vga_g, vga_b};
      S_ROW:   return {22'd0, bus.vga_read_row};
      S_COL:   return {22'd0, bus.vga_read_col};
      S_DONE:  return {31'd0, bus.vga_done};
      S_OVR:   return {24'd0, overrun_count};
      S_HS:    return {31'd0, vga_hs};
      default: return {31'd0, vga_vs};
    endcase
  endfunction

  function automatic void push(input int unsigned due, input sel_t sel,
                               input int unsigned exp, input string name);
    vec_t e;
    int   i;
    e.due = due; e.sel = sel; e.exp = exp; e.name = name;
    i = sb_q.size();
    while (i > 0 && sb_q[i-1].due > due) i--;
    sb_q.insert(i, e);
  endfunction

  // Pin value for raster position (f,v,h) is visible two ticks after its own tick
  function automatic int unsigned pix_due(input int unsigned f, v, h);
    return 2 * (f * FT + v * HT + h + 2);
  endfunction

  function automatic int unsigned tick_due(input int unsigned f, v, h);
    return 2 * (f * FT + v * HT + h + 1);
  endfunction

  task automatic wait_cyc(input int unsigned n);
    int unsigned guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (cyc != n && guard < 100000);
    if (cyc != n) chk("wait_cyc", cyc, n);
  endtask

  // Monitor: pops every vector whose due cycle has arrived
  always begin
    @(posedge clk); #1;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      vec_t e;
      e = sb_q.pop_front();
      if (e.due != cyc) chk({e.name, "_missed"}, cyc, e.due);
      else              chk(e.name, actual(e.sel), e.exp);
    end
  end

  initial begin : stimulus_table
    // picture pixels: index = col[5:0], row bits in [7:6] must be ignored
    push(pix_due(0,0,63),  S_RGB, 12'h000, "left_border");
    push(pix_due(0,0,64),  S_RGB, 12'h777, "pix_h64");
    push(pix_due(0,0,65),  S_RGB, 12'h777, "pix_h65_dup");
    push(pix_due(0,0,66),  S_RGB, 12'h00F, "pix_h66");
    push(pix_due(0,0,130), S_RGB, 12'h3BF, "pix_h130");
    push(pix_due(0,0,570), S_RGB, 12'hFDF, "pix_h570");
    push(pix_due(0,0,575), S_RGB, 12'h000, "pix_h575");
    push(pix_due(0,0,576), S_RGB, 12'h000, "right_border");
    push(pix_due(0,1,68),  S_RGB, 12'h00B, "pix_v1_h68");
    push(pix_due(0,2,68),  S_RGB, 12'h00B, "pix_hi_bits");
    push(pix_due(0,3,96),  S_RGB, 12'hBBB, "pix_v3_h96");
    push(pix_due(0,4,128), S_RGB, 12'hFFF, "pix_v4_h128");
    push(pix_due(0,5,84),  S_RGB, 12'h060, "pix_v5_h84");
    push(pix_due(0,6,100), S_RGB, 12'h000, "vblank_black");
    push(pix_due(1,3,200), S_RGB, 12'h908, "pix_f1");
    push(pix_due(4,2,300), S_RGB, 12'hFDB, "pix_before_rst");
    // addresses
    push(tick_due(0,0,20),  S_COL, 0,   "col_reset_hold");
    push(tick_due(0,0,100), S_ROW, 0,   "row_v0");
    push(tick_due(0,0,100), S_COL, 18,  "col_h100");
    push(tick_due(0,0,575), S_COL, 255, "col_h575");
    push(tick_due(0,1,20),  S_COL, 255, "col_hold_hblank");
    push(tick_due(0,1,100), S_ROW, 0,   "row_v1");
    push(tick_due(0,2,100), S_ROW, 1,   "row_v2");
    push(tick_due(0,5,100), S_ROW, 2,   "row_last");
    push(tick_due(0,7,100), S_ROW, 2,   "row_hold_vblank");
    push(tick_due(0,7,100), S_COL, 255, "col_hold_vblank");
    // syncs at the pins
    push(pix_due(0,0,643), S_HS, 1, "hs_before");
    push(pix_due(0,0,644), S_HS, 0, "hs_first");
    push(pix_due(0,0,651), S_HS, 0, "hs_last");
    push(pix_due(0,0,652), S_HS, 1, "hs_after");
    push(pix_due(0,6,655), S_VS, 1, "vs_before");
    push(pix_due(0,7,0),   S_VS, 0, "vs_first");
    push(pix_due(0,8,655), S_VS, 0, "vs_last");
    push(pix_due(0,9,0),   S_VS, 1, "vs_after");
    // handshake
    push(tick_due(0,5,655) - 1, S_DONE, 0, "done_pre");
    push(tick_due(0,5,655),     S_DONE, 1, "done_rise");
    push(8872,                  S_DONE, 1, "done_hold");
    push(8873,                  S_DONE, 0, "done_fall");
    push(tick_due(1,0,0) + 1,   S_OVR,  0, "ovr_none");
    push(15004,                 S_DONE, 0, "scan_edge_ignored");
    push(tick_due(1,5,655) - 1, S_DONE, 0, "done_pre_f1");
    push(tick_due(1,5,655),     S_DONE, 1, "done_rise_f1");
    push(tick_due(2,0,0) - 1,   S_OVR,  0, "ovr_pre1");
    push(tick_due(2,0,0),       S_OVR,  1, "ovr_1");
    push(tick_due(2,0,0),       S_DONE, 1, "done_ovr1");
    push(tick_due(3,0,0),       S_OVR,  2, "ovr_2");
    push(tick_due(3,0,0),       S_DONE, 1, "done_ovr2");
    push(tick_due(4,0,0) - 1,   S_DONE, 1, "done_pre_f4");
    push(tick_due(4,0,0),       S_DONE, 0, "done_vsync_wins");
    push(tick_due(4,0,0),       S_OVR,  2, "ovr_vsync_wins");
    push(pix_due(4,2,300),      S_OVR,  2, "ovr_before_rst");
  end

  initial begin : sync_mon
    int unsigned hs_fall = 0, hs_rise = 0, vs_fall0 = 0, vs_fall1 = 0, vs_rise = 0;
    logic ph = 1'b1, pv = 1'b1;
    @(posedge rst_n);
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk); #1;
      if (ph && !vga_hs && hs_fall == 0) hs_fall = cyc;
      if (!ph && vga_hs && hs_fall != 0 && hs_rise == 0) hs_rise = cyc;
      if (pv && !vga_vs) begin
        if (vs_fall0 == 0) vs_fall0 = cyc;
        else if (vs_fall1 == 0) vs_fall1 = cyc;
      end
      if (!pv && vga_vs && vs_fall0 != 0 && vs_rise == 0) vs_rise = cyc;
      ph = vga_hs;
      pv = vga_vs;
    end
    chk("hs_first_fall", hs_fall, 2 * (644 + 2));
    chk("hs_low_clks", hs_rise - hs_fall, 2 * 8);
    chk("vs_low_clks", vs_rise - vs_fall0, 2 * 2 * HT);
    chk("vs_period", vs_fall1 - vs_fall0, 2 * FT);
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rgb"},  {20'd0, vga_r, vga_g, vga_b}, 0);
    chk({tag, "_hs"},   {31'd0, vga_hs}, 1);
    chk({tag, "_vs"},   {31'd0, vga_vs}, 1);
    chk({tag, "_done"}, {31'd0, bus.vga_done}, 0);
    chk({tag, "_ovr"},  {24'd0, overrun_count}, 0);
    chk({tag, "_row"},  {22'd0, bus.vga_read_row}, 0);
    chk({tag, "_col"},  {22'd0, bus.vga_read_col}, 0);
  endtask

  initial begin : main
    int unsigned guard;
    bus.ppu_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_values("por");
    rst_n = 1'b1;

    wait_cyc(8872);  bus.ppu_vsync = 1'b1;
    wait_cyc(8876);  bus.ppu_vsync = 1'b0;
    wait_cyc(15000); bus.ppu_vsync = 1'b1;
    wait_cyc(15003); bus.ppu_vsync = 1'b0;
    wait_cyc(52481); bus.ppu_vsync = 1'b1;
    wait_cyc(52485); bus.ppu_vsync = 1'b0;

    // mid-frame reset at h=300, v=2 of frame 4
    wait_cyc(pix_due(4,2,300));
    #1 rst_n = 1'b0;
    #1 chk_reset_values("async_rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (vga_hs && guard < 5000);
    chk("hs_fall_after_rst", cyc, 2 * (644 + 2));

    while (sb_q.size() > 0) begin
      vec_t e;
      e = sb_q.pop_front();
      chk({e.name, "_never_checked"}, cyc, e.due);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
